// File: rtl/sram22_req_frontend_if.sv
// ---------------------------------------------------------------------------
// sram22_req_frontend_if
// Bundles the three signal groups around the sram22 request front-end:
//   request stream  : req_valid/req_ready/req_we/req_wmask/req_addr/req_wdata
//   response stream : resp_valid/resp_ready/resp_rdata
//   macro pins      : mem_rstb/mem_ce/mem_we/mem_wmask/mem_addr/mem_din/mem_dout
// Modports:
//   slave  - the front-end itself (accepts requests, produces responses,
//            drives the macro pins)
//   master - the surroundings (request producer, response consumer, macro)
// ---------------------------------------------------------------------------
interface sram22_req_frontend_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 11,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8
);
    // Request stream
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;

    // Response stream
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DATA_WIDTH-1:0]  resp_rdata;

    // Macro pins
    logic                   mem_rstb;
    logic                   mem_ce;
    logic                   mem_we;
    logic [WMASK_WIDTH-1:0] mem_wmask;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_din;
    logic [DATA_WIDTH-1:0]  mem_dout;

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata,
        input  resp_ready,
        output mem_rstb, mem_ce, mem_we, mem_wmask, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata,
        output resp_ready,
        input  mem_rstb, mem_ce, mem_we, mem_wmask, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/sram22_req_frontend.sv
// ---------------------------------------------------------------------------
// sram22_req_frontend
// Valid/ready request front-end for an sram22 macro. Requests are passed
// combinationally to the macro pins on the edge they fire; read data coming
// back one cycle later is captured into a small first-word-fall-through
// response FIFO. Reads are only accepted while a FIFO slot is guaranteed
// for them (credit rule), so a stalled consumer never loses data. Writes
// are always accepted and never produce a response.
// Ports:
//   clk  - clock, all state on posedge
//   rstb - asynchronous active-low reset (also forwarded as mem_rstb)
//   bus  - slave side of sram22_req_frontend_if (request, response, macro)
// ---------------------------------------------------------------------------
module sram22_req_frontend #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 11,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rstb,
    sram22_req_frontend_if.slave      bus
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    // FIFO state
    logic [DATA_WIDTH-1:0] r_fifo [RESP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    // High in the cycle where mem_dout carries data of a read fired last edge
    logic                  r_rd_pending;

    logic                  w_fire;
    logic                  w_rd_fire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_resp_valid;
    logic [CNT_W:0]        w_used;
    logic [CNT_W:0]        w_limit;
    logic                  w_credit;
    logic                  w_req_ready;

    assign w_resp_valid = (r_count != '0);
    assign w_pop        = w_resp_valid && bus.resp_ready;
    assign w_push       = r_rd_pending;

    // free = DEPTH - count - pending + pop; free != 0 <=> used < DEPTH + pop.
    // A slot being popped this edge can be refilled by a read fired now,
    // since its data only arrives one edge later.
    assign w_used   = {1'b0, r_count} + (CNT_W+1)'(r_rd_pending);
    assign w_limit  = (CNT_W+1)'(RESP_DEPTH) + (CNT_W+1)'(w_pop);
    assign w_credit = (w_used < w_limit);

    // Never a function of req_valid, so no combinational valid->ready loop.
    assign w_req_ready = rstb && (bus.req_we || w_credit);
    assign w_fire      = bus.req_valid && w_req_ready;
    assign w_rd_fire   = w_fire && !bus.req_we;

    // Macro drive: sampled by the macro at the same edge the request fires
    assign bus.req_ready  = w_req_ready;
    assign bus.mem_rstb   = rstb;
    assign bus.mem_ce     = w_fire;
    assign bus.mem_we     = bus.req_we;
    assign bus.mem_wmask  = bus.req_we ? bus.req_wmask : '0;
    assign bus.mem_addr   = bus.req_addr;
    assign bus.mem_din    = bus.req_wdata;

    // Response side: first-word-fall-through
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_fifo[r_rd_ptr];

    // Data storage carries no reset; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.mem_dout;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            // A read firing this edge keeps pending high for the next cycle
            r_rd_pending <= w_rd_fire;

            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The credit rule makes a push into a full FIFO impossible
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rstb)
        !(w_push && (r_count == CNT_W'(RESP_DEPTH)))
    ) else $error("sram22_req_frontend: response pushed while FIFO full");

endmodule

// File: tb/tb_sram22_req_frontend.sv
// ---------------------------------------------------------------------------
// tb_sram22_req_frontend
// Directed bench for sram22_req_frontend with a behavioural 2048x64 macro
// model (1-cycle read latency, byte-masked writes, dout held otherwise).
// ---------------------------------------------------------------------------
module tb_sram22_req_frontend;
    localparam int DW = 64;
    localparam int AW = 11;
    localparam int MW = DW / 8;
    localparam int RD = 2;

    logic clk;
    logic rstb;
    int   n_checks;
    int   n_fail;

    sram22_req_frontend_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

    sram22_req_frontend #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WMASK_WIDTH(MW),
        .RESP_DEPTH (RD)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro
    logic [DW-1:0] macro_mem [1 << AW];
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (bus.mem_wmask[b]) macro_mem[bus.mem_addr][b*8 +: 8] <= bus.mem_din[b*8 +: 8];
                end
            end else begin
                bus.mem_dout <= macro_mem[bus.mem_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [MW-1:0] mask);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_wmask = mask;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ready: got %b expected 1", bus.req_ready);
        end
        n_checks++;
        if (bus.mem_wmask !== mask) begin
            n_fail++;
            $display("FAIL wr_wmask: got %h expected %h", bus.mem_wmask, mask);
        end
        tick();
        bus.req_valid = 1'b0;
        $display("WR addr=%h data=%h mask=%h", addr, data, mask);
    endtask

    // One read with resp_ready low until the response is seen, then popped
    task automatic do_read_check(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = addr;
        bus.req_wmask  = '1;
        #1;
        n_checks++;
        if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== addr) begin
            n_fail++;
            $display("FAIL rd_drive: got ce=%b we=%b addr=%h expected ce=1 we=0 addr=%h",
                     bus.mem_ce, bus.mem_we, bus.mem_addr, addr);
        end
        n_checks++;
        if (bus.mem_wmask !== 8'h00) begin
            n_fail++;
            $display("FAIL rd_wmask: got %h expected 00", bus.mem_wmask);
        end
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_latency_early: got resp_valid=%b expected 0", bus.resp_valid);
        end
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp) begin
            n_fail++;
            $display("FAIL rd_data: got valid=%b data=%h expected valid=1 data=%h",
                     bus.resp_valid, bus.resp_rdata, exp);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_pop: got resp_valid=%b expected 0", bus.resp_valid);
        end
        $display("RD addr=%h expect=%h", addr, exp);
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.mem_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b ready=%b ce=%b expected 0 0 0",
                     bus.resp_valid, bus.req_ready, bus.mem_ce);
        end
        n_checks++;
        if (bus.mem_rstb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_rstb: got %b expected 0", bus.mem_rstb);
        end
        bus.req_valid = 1'b0;
        rstb = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_rstb !== 1'b1) begin
            n_fail++;
            $display("FAIL release_mem_rstb: got %b expected 1", bus.mem_rstb);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.resp_valid !== 1'b0 || bus.mem_ce !== 1'b0 || bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_after_reset: cycle %0d got valid=%b ce=%b ready=%b expected 0 0 1",
                         i, bus.resp_valid, bus.mem_ce, bus.req_ready);
            end
        end
        $display("RESET done");
    endtask

    task automatic test_write_read();
        do_write(11'h005, 64'h0123456789ABCDEF, 8'hFF);
        do_read_check(11'h005, 64'h0123456789ABCDEF);
    endtask

    task automatic test_partial_write();
        do_write(11'h005, 64'hFFFFFFFFFFFFFFAA, 8'h01);
        do_read_check(11'h005, 64'h0123456789ABCDAA);
        // Zero mask must leave the word untouched
        do_write(11'h005, 64'h0000000000000000, 8'h00);
        do_read_check(11'h005, 64'h0123456789ABCDAA);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_data [4];
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 3);
            do_write(AW'(i), exp_data[i], 8'hFF);
        end
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.req_valid = (k < 4);
            bus.req_we    = 1'b0;
            bus.req_addr  = AW'(k);
            #1;
            if (k < 4) begin
                n_checks++;
                if (bus.req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready: cycle %0d got %b expected 1", k, bus.req_ready);
                end
            end
            tick();
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_data[k-1]) begin
                    n_fail++;
                    $display("FAIL b2b_resp: cycle %0d got valid=%b data=%h expected valid=1 data=%h",
                             k, bus.resp_valid, bus.resp_rdata, exp_data[k-1]);
                end
            end else begin
                n_checks++;
                if (bus.resp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle: cycle %0d got valid=%b expected 0", k, bus.resp_valid);
                end
            end
            $display("B2B cycle=%0d resp_valid=%b", k, bus.resp_valid);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_stall();
        int            accepted;
        logic [DW-1:0] d10;
        logic [DW-1:0] d11;
        d10 = 64'h1010_2020_3030_4040;
        d11 = 64'h1111_2222_3333_4444;
        do_write(11'h010, d10, 8'hFF);
        do_write(11'h011, d11, 8'hFF);
        accepted = 0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = AW'(11'h010 + accepted);
            #1;
            n_checks++;
            if (bus.req_ready !== (i < 2) || bus.mem_ce !== (i < 2)) begin
                n_fail++;
                $display("FAIL stall_ready: cycle %0d got ready=%b ce=%b expected %b",
                         i, bus.req_ready, bus.mem_ce, (i < 2));
            end
            if (bus.req_ready === 1'b1) accepted++;
            tick();
        end
        n_checks++;
        if (accepted != 2) begin
            n_fail++;
            $display("FAIL stall_accepted: got %0d expected 2", accepted);
        end
        // Write still accepted while reads are blocked; overwrite 0x011 after it was captured
        bus.req_we    = 1'b1;
        bus.req_addr  = 11'h011;
        bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.req_wmask = 8'hFF;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_write_ready: got %b expected 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== d10) begin
            n_fail++;
            $display("FAIL stall_head: got valid=%b data=%h expected valid=1 data=%h",
                     bus.resp_valid, bus.resp_rdata, d10);
        end
        bus.resp_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== d11) begin
            n_fail++;
            $display("FAIL stall_second: got valid=%b data=%h expected valid=1 data=%h",
                     bus.resp_valid, bus.resp_rdata, d11);
        end
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drained: got valid=%b expected 0", bus.resp_valid);
        end
        bus.resp_ready = 1'b0;
        $display("STALL accepted=%0d drained", accepted);
    endtask

    task automatic test_reset_midop();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 11'h000;
        tick();
        bus.req_addr   = 11'h001;
        tick();
        bus.req_valid  = 1'b0;
        // Now one response buffered and one read pending
        n_checks++;
        if (bus.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_prereset: got valid=%b expected 1", bus.resp_valid);
        end
        rstb = 1'b0;
        #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_async: got valid=%b ready=%b expected 0 0",
                     bus.resp_valid, bus.req_ready);
        end
        tick();
        tick();
        rstb = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midop_stale: cycle %0d got valid=%b expected 0", i, bus.resp_valid);
            end
        end
        $display("RESET_MIDOP done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rstb           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_wmask  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        bus.mem_dout   = '0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_stall();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
